instruction_fetch_stage: RTL

Front end of the RV64 core. It owns the program counter, issues instruction fetches to a variable-latency instruction memory, and delivers one {pc, instr, pc+4} bundle per instruction into the IF/ID register consumed by the datapath. It supports downstream stall and branch/jump redirect (flush), including redirect while a fetch is outstanding.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buffer.sv | 45 ++++
 rtl/instruction_fetch_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV64 instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register that absorbs a response the IF/ID
// register cannot take, since instruction memory responses cannot be stalled.
module fetch_skid_buffer #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_unload,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [ILEN-1:0] i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [ILEN-1:0] o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [ILEN-1:0] r_instr;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  // Payload carries no reset; it is only observed while r_valid is set.
  always_ff @(posedge clock) begin
    if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/instruction_fetch_stage.sv
// RV64 fetch front end: owns the PC, issues one outstanding fetch at a time
// and fills the IF/ID register, with stall hold and redirect/flush support.
module instruction_fetch_stage #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [ILEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc_plus4
);

  import fetch_pkg::*;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~XLEN'(INSTR_BYTES - 1);
  endfunction

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] a);
    return a + XLEN'(INSTR_BYTES);
  endfunction

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_drop;
  logic            r_ifid_valid;
  logic [XLEN-1:0] r_ifid_pc;
  logic [ILEN-1:0] r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc_plus4;

  logic            w_ifid_free;
  logic            w_rsp_accept;
  logic            w_buf_load;
  logic            w_buf_unload;
  logic            w_buf_valid;
  logic [XLEN-1:0] w_buf_pc;
  logic [ILEN-1:0] w_buf_instr;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_redirect_pc = align_pc(redirect_pc);
  assign w_pc_plus4    = next_pc(r_pc);
  assign w_ifid_free   = !r_ifid_valid || !stall;
  assign w_rsp_accept  = (r_state == WAIT) && imem_rvalid && !r_drop && !redirect_valid;
  assign w_buf_load    = w_rsp_accept && !w_ifid_free;
  assign w_buf_unload  = (r_state == HOLD) && !stall && !redirect_valid && w_buf_valid;

  fetch_skid_buffer #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_buf_load),
    .i_unload (w_buf_unload),
    .i_clear  (redirect_valid),
    .i_pc     (r_pc),
    .i_instr  (imem_rdata),
    .o_valid  (w_buf_valid),
    .o_pc     (w_buf_pc),
    .o_instr  (w_buf_instr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= REQ;
      r_pc            <= RESET_PC;
      r_drop          <= 1'b0;
      r_ifid_valid    <= 1'b0;
      r_ifid_pc       <= '0;
      r_ifid_instr    <= '0;
      r_ifid_pc_plus4 <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over stall and every transition; a granted-but-unanswered
      // fetch must have its response swallowed via r_drop.
      r_pc         <= w_redirect_pc;
      r_ifid_valid <= 1'b0;
      case (r_state)
        REQ: begin
          r_state <= imem_gnt ? WAIT : REQ;
          r_drop  <= imem_gnt;
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_state <= REQ;
            r_drop  <= 1'b0;
          end else begin
            r_drop  <= 1'b1;
          end
        end
        default: begin
          r_state <= REQ;
          r_drop  <= 1'b0;
        end
      endcase
    end else begin
      if (!stall) begin
        r_ifid_valid <= 1'b0;
      end
      case (r_state)
        REQ: begin
          if (imem_gnt) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= REQ;
            end else if (w_ifid_free) begin
              r_ifid_valid    <= 1'b1;
              r_ifid_pc       <= r_pc;
              r_ifid_instr    <= imem_rdata;
              r_ifid_pc_plus4 <= w_pc_plus4;
              r_pc            <= w_pc_plus4;
              r_state         <= REQ;
            end else begin
              r_pc    <= w_pc_plus4;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (w_buf_unload) begin
            r_ifid_valid    <= 1'b1;
            r_ifid_pc       <= w_buf_pc;
            r_ifid_instr    <= w_buf_instr;
            r_ifid_pc_plus4 <= next_pc(w_buf_pc);
            r_state         <= REQ;
          end
        end
        default: begin
          r_state <= REQ;
        end
      endcase
    end
  end

  // The request is suppressed during the reset cycle itself.
  assign imem_req      = (r_state == REQ) && !reset;
  assign imem_addr     = r_pc;
  assign ifid_valid    = r_ifid_valid;
  assign ifid_pc       = r_ifid_pc;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc_plus4 = r_ifid_pc_plus4;

endmodule
